// File: rtl/ddr3_init_seq.sv
// ---------------------------------------------------------------------------
// ddr3_init_seq
// DDR3 initialisation sequencer. It waits out a power-up delay, pulses
// init_start, then waits for init_done from the controller init engine.
// Sticky init_ok / init_fail flags report the outcome. A restart in DONE or
// FAIL replays the whole sequence.
//
// Build option: define DDR3_INIT_TIMEOUT_EN to enable the WAIT_DONE watchdog,
// the BACKOFF retry path and the FAIL state. Without it, WAIT_DONE waits
// indefinitely, and init_fail and retry_cnt stay at 0.
//
// Every output is a flop loaded from the next-state decode, so each output is
// valid in the same cycle as the state it reflects.
// ---------------------------------------------------------------------------
module ddr3_init_seq #(
  parameter int DLY_CYCLES     = 60,
  parameter int DLY_W          = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13,
  parameter int BACKOFF_CYCLES = 16,
  parameter int MAX_RETRY      = 3,
  parameter int RETRY_W        = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init_done,
  input  logic               restart,
  output logic               init_start,
  output logic               init_ok,
  output logic               init_fail,
  output logic               busy,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PWR_DLY   = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_BACKOFF   = 3'd4,
    ST_DONE      = 3'd5,
    ST_FAIL      = 3'd6
  } state_e;

  localparam logic [DLY_W-1:0]   DLY_LAST  = DLY_W'(DLY_CYCLES - 1);
  localparam logic [DLY_W-1:0]   DLY_ONE   = DLY_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

  state_e             state_q, state_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [RETRY_W-1:0] retry_q, retry_d;

  logic init_start_q, init_ok_q, init_fail_q, busy_q;
  logic [2:0] state_o_q;

`ifdef DDR3_INIT_TIMEOUT_EN
  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_ONE    = TO_W'(1);
  localparam logic [DLY_W-1:0]   BO_LAST   = DLY_W'(BACKOFF_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  logic [TO_W-1:0] to_q, to_d;
`endif

  // Next-state and counter logic; all targets hold by default.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    retry_d = retry_q;
`ifdef DDR3_INIT_TIMEOUT_EN
    to_d    = to_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // The delay counter is cleared on entry to PWR_DLY.
        state_d = ST_PWR_DLY;
        dly_d   = '0;
        retry_d = '0;
      end
      ST_PWR_DLY: begin
        if (dly_q == DLY_LAST) begin
          state_d = ST_START;
        end else begin
          dly_d = dly_q + DLY_ONE;
        end
      end
      ST_START: begin
        state_d = ST_WAIT_DONE;
`ifdef DDR3_INIT_TIMEOUT_EN
        to_d    = '0;
`endif
      end
      ST_WAIT_DONE: begin
        // A done that arrives on the timeout cycle wins over the timeout.
        if (init_done) begin
          state_d = ST_DONE;
        end else begin
`ifdef DDR3_INIT_TIMEOUT_EN
          if (to_q == TO_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + RETRY_ONE;
              dly_d   = '0;
              state_d = ST_BACKOFF;
            end else begin
              state_d = ST_FAIL;
            end
          end else begin
            to_d = to_q + TO_ONE;
          end
`else
          state_d = ST_WAIT_DONE;
`endif
        end
      end
`ifdef DDR3_INIT_TIMEOUT_EN
      ST_BACKOFF: begin
        // The back-off shares the power-up delay counter.
        if (dly_q == BO_LAST) begin
          state_d = ST_START;
        end else begin
          dly_d = dly_q + DLY_ONE;
        end
      end
      ST_FAIL: begin
        if (restart) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end else begin
          state_d = ST_FAIL;
        end
      end
`endif
      ST_DONE: begin
        if (restart) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and output flops decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      dly_q        <= '0;
      retry_q      <= '0;
      init_start_q <= 1'b0;
      init_ok_q    <= 1'b0;
      init_fail_q  <= 1'b0;
      busy_q       <= 1'b0;
      state_o_q    <= 3'd0;
    end else begin
      state_q      <= state_d;
      dly_q        <= dly_d;
      retry_q      <= retry_d;
      init_start_q <= (state_d == ST_START);
      init_ok_q    <= (state_d == ST_DONE);
`ifdef DDR3_INIT_TIMEOUT_EN
      init_fail_q  <= (state_d == ST_FAIL);
`else
      init_fail_q  <= 1'b0;
`endif
      busy_q       <= (state_d == ST_PWR_DLY) || (state_d == ST_START) ||
                      (state_d == ST_WAIT_DONE) || (state_d == ST_BACKOFF);
      state_o_q    <= state_d;
    end
  end

`ifdef DDR3_INIT_TIMEOUT_EN
  // Watchdog counter for the WAIT_DONE phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`endif

  assign init_start = init_start_q;
  assign init_ok    = init_ok_q;
  assign init_fail  = init_fail_q;
  assign busy       = busy_q;
  assign retry_cnt  = retry_q;
  assign state_o    = state_o_q;

endmodule

// File: doc/ddr3_init_seq.md
# ddr3_init_seq

Parametrised DDR3 initialisation sequencer sitting between board reset and the memory controller's init engine. After a programmable power-up delay it pulses `init_start`, then waits for `init_done`. A watchdog can time out the wait, retrying after a back-off up to a retry limit before declaring failure. Sticky status outputs feed the top-level LEDs and the wiggle test logic, and a `restart` input re-runs the whole sequence.

## Interface
- `DLY_CYCLES`, 60: cycles spent in the power-up delay; range 1 .. 2^DLY_W-1.
- `DLY_W`, 8: delay counter width.
- `TIMEOUT_CYCLES`, 4096: cycles allowed in WAIT_DONE per attempt; range 1 .. 2^TO_W-1.
- `TO_W`, 13: timeout counter width.
- `BACKOFF_CYCLES`, 16: idle cycles between a timeout and the next `init_start`; range 1 .. 2^DLY_W-1 (shares the delay counter).
- `MAX_RETRY`, 3: retries after the first attempt; range 0 .. 2^RETRY_W-1.
- `RETRY_W`, 2: width of the retry counter.
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `init_done`  in  1  completion level from the controller init engine.
- `restart`  in  1  level; honoured only in DONE or FAIL.
- `init_start`  out  1  one-cycle start pulse to the controller.
- `init_ok`  out  1  sticky success flag.
- `init_fail`  out  1  sticky failure flag.
- `busy`  out  1  high in PWR_DLY, START, WAIT_DONE and BACKOFF.
- `retry_cnt`  out  RETRY_W  number of timeouts in the current run.
- `state_o`  out  3  encoded state: IDLE=0, PWR_DLY=1, START=2, WAIT_DONE=3, BACKOFF=4, DONE=5, FAIL=6.

## Operation
- All outputs are registered and decoded from the next state, so each output is valid in the same cycle as the state it reflects.
- Reset state is IDLE. While in reset, every output is 0 and every counter is 0.
- IDLE -> PWR_DLY unconditionally; the delay counter is cleared on entry.
- PWR_DLY:
  - The delay counter increments every cycle.
  - When the counter equals DLY_CYCLES-1, the next state is START.
  - `init_done` is ignored.
- START:
  - Lasts exactly one cycle, with `init_start`=1; then WAIT_DONE.
  - The timeout counter is cleared on entry to WAIT_DONE.
- WAIT_DONE:
  - If `init_done`=1, go to DONE.
  - Otherwise the timeout counter increments.
  - When it equals TIMEOUT_CYCLES-1: if `retry_cnt` < MAX_RETRY, `retry_cnt` increments and the next state is BACKOFF; otherwise FAIL.
  - `init_done` on the same cycle as the timeout: done wins and the next state is DONE.
- BACKOFF: the delay counter runs from 0; when it equals BACKOFF_CYCLES-1, the next state is START. `init_done` is ignored.
- DONE: `init_ok`=1, held until restart or reset. A later drop of `init_done` is ignored.
- FAIL: `init_fail`=1, held until restart or reset.
- Restart: `restart`=1 in DONE or FAIL goes to IDLE and clears `retry_cnt`, `init_ok` and `init_fail`. `restart` is ignored in all other states.
- Counters never wrap in normal operation; the parameter ranges above guarantee this.
- Reset mid-operation: asynchronous return to IDLE with all outputs 0, including an `init_start` pulse in flight.

## Timing
- Edge numbering: edge 1 is the first rising edge after `rst_n` deasserts. Edge 1 enters PWR_DLY.
- `init_start` is high in the cycle after edge DLY_CYCLES+1, i.e. after edge 61 with defaults, for exactly 1 cycle.
- WAIT_DONE is entered at edge S+1, where S is the edge that entered START.
- `init_done` sampled high at edge k: DONE and `init_ok` take effect at edge k. Latency is 1 cycle.
- Timeout after TIMEOUT_CYCLES cycles in WAIT_DONE. The next `init_start` follows BACKOFF_CYCLES cycles later.
- Restart sampled at edge r: IDLE at edge r, PWR_DLY at edge r+1, full delay replayed.

## Configuration
- Macro: `DDR3_INIT_TIMEOUT_EN`.
- Defined: the watchdog, BACKOFF and FAIL are implemented exactly as above.
- Undefined:
  - No timeout counter; WAIT_DONE waits indefinitely for `init_done`.
  - BACKOFF and FAIL are unreachable and removed.
  - `init_fail` and `retry_cnt` are tied to 0.
  - TIMEOUT/BACKOFF/RETRY parameters are unused.

## Test plan
Bench parameters: DLY_CYCLES=60, TIMEOUT_CYCLES=32, BACKOFF_CYCLES=4, MAX_RETRY=2.
- Nominal: release `rst_n`, raise `init_done` 10 cycles after the pulse -> one `init_start` pulse after edge 61, `init_ok`=1 the same edge `init_done` is sampled, `busy`=0, `retry_cnt`=0.
- Single retry: hold `init_done`=0 through the first attempt, raise it 5 cycles after the second `init_start` -> second pulse 32+4+1 cycles after the first, `retry_cnt`=1, `init_ok`=1.
- Exhaustion: hold `init_done`=0 -> 3 `init_start` pulses, then `init_fail`=1, `retry_cnt`=2, `state_o`=6.
- Collision: assert `init_done` on the exact timeout cycle of the first attempt -> DONE, `retry_cnt`=0.
- Restart/reset:
  - Pulse `restart` in FAIL -> flags clear, a new pulse 61 cycles later.
  - Pulse `restart` in WAIT_DONE -> ignored.
  - Drop `rst_n` in BACKOFF -> all outputs 0 immediately.
- Macro off: hold `init_done`=0 for 1000 cycles -> one pulse only, `busy`=1, `init_fail`=0.
